// File: rtl/ts_event_log353.sv
// Event timestamp logger: synchronises trigger inputs, snapshots the RTC on edges
// and queues {channel, sec, usec} records in a FIFO that the CPU drains.
module ts_event_log353 #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        trig,
  input  logic [31:0]           sec,
  input  logic [19:0]           usec,
  input  logic                  pre_we,
  input  logic                  wa,
  input  logic [15:0]           wd,
  input  logic                  pop,
  output logic                  ev_valid,
  output logic [2:0]            ev_ch,
  output logic [31:0]           ev_sec,
  output logic [19:0]           ev_usec,
  output logic [DEPTH_LOG2:0]   ev_count,
  output logic                  overflow,
  output logic                  irq
);

  localparam int unsigned CW    = 3;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned NW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [31:0]   sec;
    logic [19:0]   usec;
  } entry_t;

  logic            r_we, r_wa, r_irq_en;
  logic [NCH-1:0]  r_en, r_pol;
  logic [NCH-1:0]  r_s1, r_s2, r_s3;
  logic [NCH-1:0]  r_pend;
  logic [31:0]     r_snap_sec  [NCH];
  logic [19:0]     r_snap_usec [NCH];
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [NW-1:0]   r_cnt;
  logic            r_ovf, r_ev_valid, r_irq;
  entry_t          r_ev;

  logic            w_ctl_wr, w_clr, w_flush, w_irq_en_nxt;
  logic [NCH-1:0]  w_edge, w_win, w_accept;
  logic            w_req, w_drop, w_full, w_do_pop, w_do_push, w_push_lost;
  entry_t          w_push, w_head_nxt;
  logic [NW-1:0]   w_cnt_nxt;
  logic [AW-1:0]   w_rd_nxt;
  logic            w_valid_nxt;
  logic            w_unused_wd;

  assign w_ctl_wr     = r_we & ~r_wa;
  assign w_clr        = r_we & r_wa & wd[0];
  assign w_flush      = r_we & r_wa & wd[1];
  assign w_irq_en_nxt = w_ctl_wr ? wd[15] : r_irq_en;
  assign w_unused_wd  = ^wd;

  assign w_edge = r_en & ((~r_pol & r_s2 & ~r_s3) | (r_pol & ~r_s2 & r_s3));

  // Lowest-index pending channel wins the single FIFO write slot.
  always_comb begin
    w_req  = 1'b0;
    w_win  = '0;
    w_push = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_pend[i] && !w_req) begin
        w_req       = 1'b1;
        w_win[i]    = 1'b1;
        w_push.ch   = CW'(i);
        w_push.sec  = r_snap_sec[i];
        w_push.usec = r_snap_usec[i];
      end
    end
  end

  // A pending slot that is being drained this cycle can take a new edge.
  assign w_accept    = w_edge & ~(r_pend & ~w_win);
  assign w_drop      = |(w_edge & r_pend & ~w_win);
  assign w_full      = (r_cnt == NW'(DEPTH));
  assign w_do_pop    = pop & (r_cnt != '0) & ~w_flush;
  assign w_do_push   = w_req & (~w_full | w_do_pop) & ~w_flush;
  assign w_push_lost = w_req & w_full & ~w_do_pop & ~w_flush;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_rd_nxt  = r_rd;
    if (w_flush) begin
      w_cnt_nxt = '0;
      w_rd_nxt  = '0;
    end else begin
      if (w_do_push) w_cnt_nxt = w_cnt_nxt + NW'(1);
      if (w_do_pop) begin
        w_cnt_nxt = w_cnt_nxt - NW'(1);
        w_rd_nxt  = r_rd + AW'(1);
      end
    end
  end

  // Head entry bypasses memory when the pushed record becomes the only entry.
  always_comb begin
    w_valid_nxt = (w_cnt_nxt != '0);
    w_head_nxt  = '0;
    if (w_valid_nxt) begin
      if (w_do_push && ((r_cnt - NW'(w_do_pop)) == '0)) w_head_nxt = w_push;
      else                                              w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(negedge mclk) begin
    if (w_do_push) r_mem[r_wr] <= w_push;
  end

  always_ff @(negedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_wa       <= 1'b0;
      r_en       <= '0;
      r_pol      <= '0;
      r_irq_en   <= 1'b0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_pend     <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_snap_sec[i]  <= '0;
        r_snap_usec[i] <= '0;
      end
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev       <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_we     <= pre_we;
      r_wa     <= wa;
      r_irq_en <= w_irq_en_nxt;
      if (w_ctl_wr) begin
        r_en  <= wd[NCH-1:0];
        r_pol <= wd[8+NCH-1:8];
      end
      r_s1 <= trig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      for (int i = 0; i < NCH; i++) begin
        if (w_flush) begin
          r_pend[i] <= 1'b0;
        end else if (w_accept[i]) begin
          r_pend[i]      <= 1'b1;
          r_snap_sec[i]  <= sec;
          r_snap_usec[i] <= usec;
        end else if (w_win[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_flush)        r_wr <= '0;
      else if (w_do_push) r_wr <= r_wr + AW'(1);
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_drop || w_push_lost) r_ovf <= 1'b1;
      else if (w_clr)            r_ovf <= 1'b0;
      r_ev_valid <= w_valid_nxt;
      r_ev       <= w_head_nxt;
      r_irq      <= w_valid_nxt & w_irq_en_nxt;
    end
  end

  assign ev_valid = r_ev_valid;
  assign ev_ch    = r_ev.ch;
  assign ev_sec   = r_ev.sec;
  assign ev_usec  = r_ev.usec;
  assign ev_count = r_cnt;
  assign overflow = r_ovf;
  assign irq      = r_irq;

endmodule
